refill_return_buffer: RTL and testbench

- Parametrised line-assembly buffer between the AXI read-return path and the I/D cache refill logic.
- Collects a refill line one beat per word in wrapping order, starting at the requested word.
- Returns the critical word early, signals line completion and holds the assembled line for the cache write.
- Also provides a combinational word read-out for hit-under-refill forwarding.

---
 rtl/refill_return_buffer.sv | 125 ++++++++++++
 tb/tb_refill_return_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/refill_return_buffer.sv
// Line-assembly buffer for cache refills: collects wrapping-order return beats,
// pulses the critical word early and presents the completed line for one cycle.
module refill_return_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int OFFSET_W   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [OFFSET_W-1:0]              start_offset,
    input  logic                             beat_valid,
    input  logic [WORD_WIDTH-1:0]            beat_data,
    input  logic                             beat_last,
    output logic                             beat_ready,
    output logic                             crit_valid,
    output logic [WORD_WIDTH-1:0]            crit_word,
    output logic                             line_valid,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] line_data,
    output logic [LINE_WORDS-1:0]            word_mask,
    input  logic [OFFSET_W-1:0]              rd_offset,
    output logic [WORD_WIDTH-1:0]            rd_word,
    output logic                             rd_hit,
    output logic                             busy,
    output logic                             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [LINE_WORDS*WORD_WIDTH-1:0] line_q, line_d;
    logic [LINE_WORDS-1:0]            mask_q, mask_d;
    logic [OFFSET_W-1:0]              ptr_q, ptr_d;
    logic [OFFSET_W-1:0]              cnt_q, cnt_d;
    logic                             crit_v_q, crit_v_d;
    logic [WORD_WIDTH-1:0]            crit_w_q, crit_w_d;
    logic                             err_q, err_d;
    logic                             final_beat;

    // beat_cnt never exceeds LINE_WORDS-1 in FILL: the LINE_WORDS-th beat always leaves FILL
    assign final_beat = (cnt_q == OFFSET_W'(LINE_WORDS - 1));

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        crit_v_d = 1'b0;
        crit_w_d = crit_w_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = start_offset;
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (beat_valid) begin
                    line_d[ptr_q*WORD_WIDTH +: WORD_WIDTH] = beat_data;
                    mask_d[ptr_q] = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        crit_v_d = 1'b1;
                        crit_w_d = beat_data;
                    end
                    if (beat_last && final_beat) begin
                        state_d = DONE;
                    end else if (beat_last || final_beat) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            line_q   <= '0;
            mask_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            crit_v_q <= 1'b0;
            crit_w_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            mask_q   <= mask_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            crit_v_q <= crit_v_d;
            crit_w_q <= crit_w_d;
            err_q    <= err_d;
        end
    end

    assign beat_ready = (state_q == FILL);
    assign busy       = (state_q == FILL) || (state_q == DONE);
    assign line_valid = (state_q == DONE);
    assign crit_valid = crit_v_q;
    assign crit_word  = crit_w_q;
    assign err        = err_q;
    assign line_data  = line_q;
    assign word_mask  = mask_q;
    assign rd_word    = line_q[rd_offset*WORD_WIDTH +: WORD_WIDTH];
    assign rd_hit     = mask_q[rd_offset] && busy;

endmodule

// File: tb/tb_refill_return_buffer.sv
// Directed bench for refill_return_buffer: a 4-word and an 8-word instance
// driven by linear stimulus with hand-computed expectations.
module tb_refill_return_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start4 = 1'b0, bv4 = 1'b0, bl4 = 1'b0;
    logic [1:0]   off4 = '0, rdo4 = '0;
    logic [31:0]  bd4 = '0;
    logic         br4, cv4, lv4, rh4, busy4, err4;
    logic [31:0]  cw4, rw4;
    logic [127:0] ld4;
    logic [3:0]   wm4;

    logic         start8 = 1'b0, bv8 = 1'b0, bl8 = 1'b0;
    logic [2:0]   off8 = '0, rdo8 = '0;
    logic [31:0]  bd8 = '0;
    logic         br8, cv8, lv8, rh8, busy8, err8;
    logic [31:0]  cw8, rw8;
    logic [255:0] ld8;
    logic [7:0]   wm8;
    logic [255:0] exp8;

    int n_cmp = 0;
    int n_bad = 0;

    refill_return_buffer #(.WORD_WIDTH(32), .LINE_WORDS(4), .OFFSET_W(2)) u4 (
        .clk(clk), .rst(rst), .start(start4), .start_offset(off4),
        .beat_valid(bv4), .beat_data(bd4), .beat_last(bl4), .beat_ready(br4),
        .crit_valid(cv4), .crit_word(cw4), .line_valid(lv4), .line_data(ld4),
        .word_mask(wm4), .rd_offset(rdo4), .rd_word(rw4), .rd_hit(rh4),
        .busy(busy4), .err(err4)
    );

    refill_return_buffer #(.WORD_WIDTH(32), .LINE_WORDS(8), .OFFSET_W(3)) u8 (
        .clk(clk), .rst(rst), .start(start8), .start_offset(off8),
        .beat_valid(bv8), .beat_data(bd8), .beat_last(bl8), .beat_ready(br8),
        .crit_valid(cv8), .crit_word(cw8), .line_valid(lv8), .line_data(ld8),
        .word_mask(wm8), .rd_offset(rdo8), .rd_word(rw8), .rd_hit(rh8),
        .busy(busy8), .err(err8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat4(input logic [31:0] d, input logic last);
        bv4 = 1'b1; bd4 = d; bl4 = last;
        tick();
        bv4 = 1'b0; bl4 = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_ready", br4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_line", ld4, 0);
        chk("rst_mask", wm4, 0);
        chk("rst_crit", cv4, 0);
        chk("rst_lv", lv4, 0);
        chk("rst_err", err4, 0);
        chk("rst_busy8", busy8, 0);
        rst = 1'b0;

        // aligned refill
        start4 = 1'b1; off4 = 2'd0; tick(); start4 = 1'b0;
        chk("t1_ready", br4, 1);
        chk("t1_busy", busy4, 1);
        beat4(32'hA0, 1'b0);
        chk("t1_cv", cv4, 1);
        chk("t1_cw", cw4, 32'hA0);
        beat4(32'hA1, 1'b0);
        chk("t1_cv_drop", cv4, 0);
        beat4(32'hA2, 1'b0);
        chk("t1_lv_early", lv4, 0);
        beat4(32'hA3, 1'b1);
        chk("t1_lv", lv4, 1);
        chk("t1_line", ld4, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_mask", wm4, 4'b1111);
        chk("t1_done_busy", busy4, 1);
        chk("t1_done_ready", br4, 0);
        tick();
        chk("t1_lv_pulse", lv4, 0);
        chk("t1_idle_busy", busy4, 0);
        chk("t1_idle_rdhit", rh4, 0);

        // wrapped refill from word 2
        start4 = 1'b1; off4 = 2'd2; tick(); start4 = 1'b0;
        beat4(32'hB2, 1'b0);
        chk("t2_cw", cw4, 32'hB2);
        beat4(32'hB3, 1'b0);
        beat4(32'hB0, 1'b0);
        beat4(32'hB1, 1'b1);
        chk("t2_lv", lv4, 1);
        chk("t2_line", ld4, 128'h000000B3_000000B2_000000B1_000000B0);
        tick();

        // gapped beats with forwarding on word 3
        rdo4 = 2'd3;
        start4 = 1'b1; off4 = 2'd0; tick(); start4 = 1'b0;
        beat4(32'hC0, 1'b0); tick();
        beat4(32'hC1, 1'b0); tick();
        beat4(32'hC2, 1'b0);
        chk("t3_rdhit_pre", rh4, 0);
        tick();
        bv4 = 1'b1; bd4 = 32'hC3; bl4 = 1'b1;
        #1;
        chk("t3_rdhit_same", rh4, 0);
        chk("t3_rdword_old", rw4, 32'hB3);
        tick();
        bv4 = 1'b0; bl4 = 1'b0;
        chk("t3_rdhit", rh4, 1);
        chk("t3_rdword", rw4, 32'hC3);
        chk("t3_lv", lv4, 1);
        rdo4 = 2'd1;
        #1;
        chk("t3_rdword1", rw4, 32'hC1);
        tick();
        chk("t3_rdhit_idle", rh4, 0);

        // early beat_last
        start4 = 1'b1; off4 = 2'd1; tick(); start4 = 1'b0;
        beat4(32'hD1, 1'b0);
        beat4(32'hD2, 1'b1);
        chk("t4_err", err4, 1);
        chk("t4_lv", lv4, 0);
        chk("t4_mask", wm4, 4'b0110);
        chk("t4_busy", busy4, 0);
        chk("t4_line", ld4, 128'h000000C3_000000D2_000000D1_000000C0);
        tick();
        chk("t4_err_pulse", err4, 0);

        // missing beat_last on the final beat
        start4 = 1'b1; off4 = 2'd0; tick(); start4 = 1'b0;
        chk("t5_busy", busy4, 1);
        beat4(32'h10, 1'b0);
        beat4(32'h11, 1'b0);
        beat4(32'h12, 1'b0);
        beat4(32'h13, 1'b0);
        chk("t5_err", err4, 1);
        chk("t5_lv", lv4, 0);
        chk("t5_mask", wm4, 4'b1111);
        chk("t5_busy_after", busy4, 0);
        tick();

        // reset mid-fill, then a clean refill
        start4 = 1'b1; off4 = 2'd0; tick(); start4 = 1'b0;
        beat4(32'hE0, 1'b0);
        beat4(32'hE1, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_ready", br4, 0);
        chk("t6_busy", busy4, 0);
        chk("t6_mask", wm4, 0);
        chk("t6_line", ld4, 0);
        chk("t6_lv", lv4, 0);
        chk("t6_err", err4, 0);
        chk("t6_cv", cv4, 0);
        start4 = 1'b1; off4 = 2'd3; tick(); start4 = 1'b0;
        beat4(32'hF3, 1'b0);
        chk("t6_cw", cw4, 32'hF3);
        beat4(32'hF0, 1'b0);
        beat4(32'hF1, 1'b0);
        beat4(32'hF2, 1'b1);
        chk("t6_lv2", lv4, 1);
        chk("t6_line2", ld4, 128'h000000F3_000000F2_000000F1_000000F0);
        tick();

        // 8-word line from offset 7, start held high throughout
        for (int w = 0; w < 8; w++) exp8[w*32 +: 32] = 32'h800 + w;
        start8 = 1'b1; off8 = 3'd7; tick();
        off8 = 3'd2;
        for (int k = 0; k < 8; k++) begin
            bv8 = 1'b1; bd8 = 32'h800 + ((7 + k) % 8); bl8 = (k == 7);
            tick();
            if (k == 0) chk("t7_cw", cw8, 32'h807);
            if (k == 6) chk("t7_lv_early", lv8, 0);
        end
        bv8 = 1'b0; bl8 = 1'b0;
        chk("t7_lv", lv8, 1);
        chk("t7_mask", wm8, 8'hFF);
        chk("t7_line", ld8, exp8);
        chk("t7_err", err8, 0);
        tick();
        chk("t7_done_start_ignored", busy8, 0);
        tick();
        chk("t7_idle_start", busy8, 1);
        chk("t7_idle_ready", br8, 1);
        start8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
